// File: rtl/demux64_scatter_pkg.sv
// Shared constants, state encoding and lane-select decode for the 64-lane scatter block.
package demux64_scatter_pkg;

    localparam int LANES = 64;
    localparam int IDX_W = 6;
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One-hot decode of a lane index into a 64-bit select vector.
    function automatic logic [LANES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [LANES-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One output lane: N-bit data register plus a loaded flag.
// The write enable beats clear on the flag, so a lane written on the same
// edge as a global clear stays marked as loaded. Clear never touches data.
module demux_lane #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we_i,
    input  logic         clr_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o,
    output logic         vld_o
);

    logic [N-1:0] data_q;
    logic         vld_q;

    // Data register: loads only on write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       data_q <= '0;
        else if (we_i) data_q <= d_i;
    end

    // Loaded flag: write sets, clear resets, write has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        vld_q <= 1'b0;
        else if (we_i)  vld_q <= 1'b1;
        else if (clr_i) vld_q <= 1'b0;
    end

    assign q_o   = data_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/demux64_scatter.sv
// Scatter a burst of words into consecutive lanes (mod 64) starting at a
// base lane. The FSM sequences IDLE -> LOAD -> DONE; each accepted word is
// written to lane idx and idx advances with wrap.
module demux64_scatter #(
    parameter int N     = 16,
    parameter int LANES = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [demux64_scatter_pkg::IDX_W-1:0] base_idx,
    input  logic [demux64_scatter_pkg::CNT_W-1:0] count,
    input  logic [N-1:0]                         in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 clr,
    output logic [LANES*N-1:0]                   out_bus,
    output logic [LANES-1:0]                     out_vld,
    output logic                                 busy,
    output logic                                 done
);

    import demux64_scatter_pkg::*;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             xfer;
    logic [LANES-1:0] lane_we;

    assign xfer    = in_valid && in_ready;
    assign lane_we = xfer ? idx_onehot(idx_q) : '0;

    // State, lane pointer and remaining-word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
        end
    end

    // Next state: start is only honoured in IDLE; LOAD advances per transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = base_idx;
                    rem_d   = count;
                    state_d = (count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    idx_d = idx_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == 7'd1) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from state only so in_ready never depends on in_valid.
    always_comb begin
        in_ready = (state_q == ST_LOAD);
        busy     = (state_q == ST_LOAD);
        done     = (state_q == ST_DONE);
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        demux_lane #(.N(N)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we_i  (lane_we[k]),
            .clr_i (clr),
            .d_i   (in_data),
            .q_o   (out_bus[k*N +: N]),
            .vld_o (out_vld[k])
        );
    end

endmodule

// File: tb/tb_demux64_scatter.sv
// Self-checking bench for demux64_scatter: directed scenarios plus a random
// soak, all checked against a burst-level behavioural model.
module tb_demux64_scatter;

    localparam int N = 16;
    localparam int W = 64 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   base_idx = '0;
    logic [6:0]   count = '0;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         clr = 1'b0;
    logic         in_ready, busy, done;
    logic [W-1:0] out_bus;
    logic [63:0]  out_vld;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;

    // Behavioural model: phase 0 idle, 1 loading, 2 finishing.
    logic [N-1:0] m_lane [64];
    logic [63:0]  m_vld;
    int           m_ph, m_next, m_left;

    logic [N-1:0] w [4];
    logic [63:0]  vld_save;
    int           d0;

    demux64_scatter #(.N(N), .LANES(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_idx (base_idx),
        .count    (count),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clr      (clr),
        .out_bus  (out_bus),
        .out_vld  (out_vld),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 64; k++) m_lane[k] = '0;
        m_vld  = '0;
        m_ph   = 0;
        m_next = 0;
        m_left = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        if (clr) m_vld = '0;
        if (m_ph == 1 && in_valid) begin
            m_lane[m_next] = in_data;
            m_vld[m_next]  = 1'b1;
            m_next = (m_next + 1) % 64;
            m_left = m_left - 1;
            if (m_left == 0) m_ph = 2;
        end else if (m_ph == 2) begin
            m_ph = 0;
        end else if (m_ph == 0 && start) begin
            m_next = int'(base_idx);
            m_left = int'(count);
            m_ph   = (count == 0) ? 2 : 1;
        end
    endtask

    task automatic check_all();
        logic [W-1:0] eb;
        for (int k = 0; k < 64; k++) eb[k*N +: N] = m_lane[k];
        chk("bus", out_bus, eb);
        chk("vld", W'(out_vld), W'(m_vld));
        chk("rdy", W'(in_ready), W'(m_ph == 1));
        chk("busy", W'(busy), W'(m_ph == 1));
        chk("done", W'(done), W'(m_ph == 2));
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later;
    // start and clr are one-cycle pulses.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (done) done_seen++;
        start = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic go(input logic [5:0] b, input logic [6:0] c);
        start = 1'b1; base_idx = b; count = c;
        cycle();
    endtask

    task automatic word(input logic [N-1:0] d);
        in_valid = 1'b1; in_data = d;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1 check_all();
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // Basic burst into lanes 0..3.
        go(6'd0, 7'd4);
        for (int i = 0; i < 4; i++) word(N'(16'h1111 * (i + 1)));
        chk("r37_vld", W'(out_vld), W'(64'h000F));
        chk("r37_l3", W'(out_bus[3*N +: N]), W'(16'h4444));
        chk("r37_done", W'(done), W'(1'b1));
        cycle();
        chk("r37_done_end", W'(done), W'(1'b0));

        // Wrap from lane 62 round to lane 1.
        go(6'd62, 7'd4);
        for (int i = 0; i < 4; i++) begin
            w[i] = N'($urandom);
            word(w[i]);
        end
        chk("r38_l62", W'(out_bus[62*N +: N]), W'(w[0]));
        chk("r38_l63", W'(out_bus[63*N +: N]), W'(w[1]));
        chk("r38_l0", W'(out_bus[0 +: N]), W'(w[2]));
        chk("r38_l1", W'(out_bus[1*N +: N]), W'(w[3]));
        chk("r38_vld", W'(out_vld & 64'hC000_0000_0000_0003), W'(64'hC000_0000_0000_0003));
        cycle();

        // Empty burst.
        vld_save = out_vld;
        go(6'd9, 7'd0);
        chk("r39_done", W'(done), W'(1'b1));
        chk("r39_rdy", W'(in_ready), W'(1'b0));
        chk("r39_vld", W'(out_vld), W'(vld_save));
        cycle();

        // Stalled burst with a stray start in the middle.
        d0 = done_seen;
        go(6'd20, 7'd3);
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < 5; g++) begin
                if (i == 1 && g == 2) begin
                    start = 1'b1; base_idx = 6'd40; count = 7'd2;
                end
                cycle();
            end
            word(N'($urandom));
        end
        repeat (3) cycle();
        chk("r40_done_cnt", W'(done_seen - d0), W'(1));
        chk("r40_vld", W'(out_vld[40] | out_vld[23]), W'(1'b0));

        // Clear coincident with a write to lane 5.
        clr = 1'b1; cycle();
        go(6'd0, 7'd8);
        for (int i = 0; i < 8; i++) word(N'($urandom));
        cycle();
        chk("r41_pre", W'(out_vld), W'(64'h00FF));
        go(6'd5, 7'd1);
        clr = 1'b1;
        word(16'hBEEF);
        chk("r41_vld", W'(out_vld), W'(64'h0020));
        chk("r41_l5", W'(out_bus[5*N +: N]), W'(16'hBEEF));
        cycle();

        // Reset in the middle of a burst.
        d0 = done_seen;
        go(6'd30, 7'd4);
        word(N'($urandom));
        word(N'($urandom));
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("r42_bus0", out_bus, '0);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (3) cycle();
        chk("r42_nodone", W'(done_seen - d0), W'(0));
        go(6'd30, 7'd2);
        word(16'h0A0A);
        word(16'h0B0B);
        cycle();
        chk("r42_done", W'(done_seen - d0), W'(1));
        chk("r42_l31", W'(out_bus[31*N +: N]), W'(16'h0B0B));

        // Random soak.
        for (int c = 0; c < 600; c++) begin
            start    = ($urandom_range(0, 5) == 0);
            base_idx = 6'($urandom);
            count    = 7'($urandom_range(0, 64));
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = N'($urandom);
            clr      = ($urandom_range(0, 19) == 0);
            rst      = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux64_scatter.md
DEMUX64_SCATTER -- requirements
Module: demux64_scatter

Interface
REQ-001 SHALL have parameter N, default 16, meaning bit width of each data word and each output lane.
REQ-002 SHALL have parameter LANES, fixed at 64, meaning number of output lanes (lane index 6 bits).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a scatter burst.
REQ-006 SHALL have port base_idx  input  6  first lane written; sampled on accepted start.
REQ-007 SHALL have port count  input  7  words in burst, 0..64; sampled on accepted start.
REQ-008 SHALL have port in_data  input  N  incoming word.
REQ-009 SHALL have port in_valid  input  1  in_data valid.
REQ-010 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-011 SHALL have port clr  input  1  clear all lane-loaded flags.
REQ-012 SHALL have port out_bus  output  64*N  lane registers, lane k at bits [k*N +: N].
REQ-013 SHALL have port out_vld  output  64  per-lane loaded flag.
REQ-014 SHALL have port busy  output  1  high in LOAD state.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement states IDLE, LOAD, DONE.
REQ-017 IDLE: start=1 SHALL latch base_idx into idx and count into remaining; next state LOAD if count>0, DONE if count=0.
REQ-018 start while in LOAD or DONE SHALL be ignored, no effect on idx, remaining or state.
REQ-019 in_ready SHALL equal 1 exactly when state is LOAD; combinational from state only, not from in_valid.
REQ-020 Transfer SHALL occur on a clock edge where in_valid=1 and in_ready=1.
REQ-021 On transfer, lane idx SHALL load in_data and out_vld[idx] SHALL set; visible in out_bus/out_vld the following cycle (latency 1).
REQ-022 On transfer, idx SHALL increment modulo 64 (63 wraps to 0) and remaining SHALL decrement.
REQ-023 Transfer with remaining=1 SHALL move state to DONE; otherwise state stays LOAD.
REQ-024 in_valid=0 in LOAD SHALL hold all state (stall, no timeout).
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 Lanes not written SHALL retain their previous contents; count=64 writes every lane once.
REQ-027 clr=1 SHALL clear all out_vld bits next cycle; lane data SHALL NOT be cleared.
REQ-028 clr coincident with a transfer: all flags SHALL clear except out_vld[idx], which SHALL set (write wins).
REQ-029 clr SHALL NOT affect state, idx, remaining or handshake.
REQ-030 Accepted start coincident with clr SHALL act on both.

Reset
REQ-031 rst=1 SHALL immediately, independent of clk, force state IDLE, idx 0, remaining 0, out_bus all 0, out_vld all 0, done 0, busy 0, in_ready 0.
REQ-032 rst asserted mid-burst SHALL abandon the burst; no done pulse SHALL follow.
REQ-033 After rst release, first accepted start SHALL behave per REQ-017.

Structure
REQ-034 Shared package SHALL hold LANES=64, IDX_W=6, CNT_W=7 and the state enumeration.
REQ-035 Per-lane storage SHALL be one sub-module, demux_lane (N-bit register + loaded flag, write-enable, clear), instantiated 64 times.
REQ-036 Lane write-enable SHALL be a one-hot 6-to-64 decode of idx gated by transfer.

Verification
REQ-037 Reset, then start base_idx=0 count=4, words 0x1111..0x4444 back-to-back -> lanes 0..3 hold them, out_vld=0x000F, done pulses 1 cycle after 4th transfer.
REQ-038 start base_idx=62 count=4, words A,B,C,D -> lanes 62,63,0,1 = A,B,C,D (wrap), out_vld bits 62,63,0,1 set.
REQ-039 start count=0 -> no in_ready, done pulses the cycle after start, out_vld unchanged.
REQ-040 count=3 with in_valid low 5 cycles between words, plus start pulsed mid-burst -> exactly 3 lanes written, extra start ignored, single done.
REQ-041 clr on same edge as transfer to lane 5 with flags 0x00FF set -> out_vld=0x0020, lane data 0..7 unchanged.
REQ-042 rst asserted after 2 of 4 words -> all outputs 0 immediately, no done, IDLE; new burst then completes normally.
